// File: rtl/somador_serial_param.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock over WIDTH/CHUNK cycles, valid/ready on both sides.
// Define SOMADOR_FLAGS_EN to compile in the ovf/zero flags; otherwise both ports are tied to 0.
module somador_serial_param #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH:0]   s_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK:0]   chunkSum;
    logic [WIDTH-1:0] result_d;

    // Chunk k is selected by comparing against every constant slot, keeping the ripple only CHUNK bits long.
    always_comb begin
        aChunk   = '0;
        bChunk   = '0;
        result_d = s_q[WIDTH-1:0];
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                aChunk = a_q[i*CHUNK +: CHUNK];
                bChunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunkSum = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                result_d[i*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{op}};
                        carry_q    <= op;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    s_q[WIDTH-1:0] <= result_d;
                    carry_q        <= chunkSum[CHUNK];
                    k_q            <= k_q + KW'(1);
                    if (k_q == LAST_K) begin
                        s_q[WIDTH]  <= chunkSum[CHUNK];
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;

`ifdef SOMADOR_FLAGS_EN
    logic ovf_q;
    logic zero_q;
    logic ovfChunk;

    // Same operand signs but a different result sign is equivalent to carry-in XOR carry-out at the MSB.
    assign ovfChunk = (aChunk[CHUNK-1] == bChunk[CHUNK-1]) && (chunkSum[CHUNK-1] != aChunk[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state_q == CALC && k_q == LAST_K) begin
            ovf_q  <= ovfChunk;
            zero_q <= (result_d == '0);
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_somador_serial_param.sv
// Self-checking bench for somador_serial_param: CHUNK=4 and CHUNK=1 instances against an arithmetic reference model.
// Flag expectations follow SOMADOR_FLAGS_EN so the bench matches either build.
module tb_somador_serial_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] aV[2];
    logic [7:0] bV[2];
    logic       opV[2];
    logic       inValidV[2];
    logic       outReadyV[2];
    logic       inReadyV[2];
    logic       outValidV[2];
    logic       ovfV[2];
    logic       zeroV[2];
    logic [8:0] sV[2];

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    somador_serial_param #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .a(aV[0]), .b(bV[0]), .op(opV[0]),
        .in_valid(inValidV[0]), .in_ready(inReadyV[0]), .s(sV[0]),
        .out_valid(outValidV[0]), .out_ready(outReadyV[0]), .ovf(ovfV[0]), .zero(zeroV[0])
    );

    somador_serial_param #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .a(aV[1]), .b(bV[1]), .op(opV[1]),
        .in_valid(inValidV[1]), .in_ready(inReadyV[1]), .s(sV[1]),
        .out_valid(outValidV[1]), .out_ready(outReadyV[1]), .ovf(ovfV[1]), .zero(zeroV[1])
    );

    // Result as {ovf, zero, carry, low byte}, derived from integer arithmetic on the operands.
    function automatic logic [10:0] refModel(input logic [7:0] x, input logic [7:0] y, input logic sub);
        int sx, sy, sres, ures;
        logic carry, ovfE, zeroE;
        logic [7:0] low;
        sx    = int'($signed(x));
        sy    = int'($signed(y));
        sres  = sub ? sx - sy : sx + sy;
        ures  = sub ? int'(x) - int'(y) : int'(x) + int'(y);
        low   = ures[7:0];
        carry = sub ? (x >= y) : (ures > 255);
`ifdef SOMADOR_FLAGS_EN
        ovfE  = (sres > 127) || (sres < -128);
        zeroE = (low == 8'd0);
`else
        ovfE  = 1'b0;
        zeroE = 1'b0;
`endif
        return {ovfE, zeroE, carry, low};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkResetState(input int d);
        checkOutput($sformatf("d%0d rst in_ready", d), inReadyV[d], 1);
        checkOutput($sformatf("d%0d rst out_valid", d), outValidV[d], 0);
        checkOutput($sformatf("d%0d rst s", d), sV[d], 0);
        checkOutput($sformatf("d%0d rst ovf", d), ovfV[d], 0);
        checkOutput($sformatf("d%0d rst zero", d), zeroV[d], 0);
    endtask

    // One full transaction: accept, measure latency, check result, stall the consumer, then hand off.
    task automatic applyStimulus(input int d, input logic [7:0] x, input logic [7:0] y,
                                 input logic sub, input int stall);
        int n;
        int lat;
        logic [10:0] e;
        string id;
        n  = (d == 0) ? 2 : 8;
        e  = refModel(x, y, sub);
        id = $sformatf("d%0d %0d%s%0d", d, x, sub ? "-" : "+", y);
        @(negedge clk);
        checkOutput({id, " idle in_ready"}, inReadyV[d], 1);
        aV[d] = x; bV[d] = y; opV[d] = sub; inValidV[d] = 1'b1; outReadyV[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inValidV[d] = 1'b0;
        aV[d] = 8'($urandom); bV[d] = 8'($urandom); opV[d] = 1'($urandom);
        checkOutput({id, " busy in_ready"}, inReadyV[d], 0);
        lat = 0;
        while (outValidV[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({id, " latency"}, lat, n);
        checkOutput({id, " s"}, sV[d], e[8:0]);
        checkOutput({id, " ovf"}, ovfV[d], e[10]);
        checkOutput({id, " zero"}, zeroV[d], e[9]);
        for (int i = 0; i < stall; i++) begin
            inValidV[d] = 1'b1;
            aV[d] = 8'($urandom); bV[d] = 8'($urandom); opV[d] = 1'($urandom);
            @(negedge clk);
            checkOutput({id, " stall s"}, sV[d], e[8:0]);
            checkOutput({id, " stall ovf"}, ovfV[d], e[10]);
            checkOutput({id, " stall zero"}, zeroV[d], e[9]);
            checkOutput({id, " stall in_ready"}, inReadyV[d], 0);
            checkOutput({id, " stall out_valid"}, outValidV[d], 1);
        end
        outReadyV[d] = 1'b1;
        inValidV[d]  = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        outReadyV[d] = 1'b0;
        inValidV[d]  = 1'b0;
        checkOutput({id, " post in_ready"}, inReadyV[d], 1);
        checkOutput({id, " post out_valid"}, outValidV[d], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            aV[d] = '0; bV[d] = '0; opV[d] = 1'b0; inValidV[d] = 1'b0; outReadyV[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState(0);
        checkResetState(1);
        rst = 1'b0;

        applyStimulus(0, 8'd200, 8'd100, 1'b0, 0);
        applyStimulus(0, 8'd5,   8'd7,   1'b1, 5);
        applyStimulus(0, 8'd100, 8'd100, 1'b1, 1);
        applyStimulus(0, 8'd0,   8'd0,   1'b0, 0);
        applyStimulus(0, 8'd128, 8'd1,   1'b1, 2);
        applyStimulus(0, 8'd255, 8'd255, 1'b0, 0);
        applyStimulus(0, 8'd0,   8'd1,   1'b1, 0);
        applyStimulus(0, 8'd77,  8'd0,   1'b1, 0);
        applyStimulus(1, 8'd127, 8'd1,   1'b0, 1);
        applyStimulus(1, 8'd255, 8'd1,   1'b0, 0);
        applyStimulus(1, 8'd3,   8'd200, 1'b1, 2);

        for (int i = 0; i < 20; i++)
            applyStimulus(0, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // Reset lands during CALC of 255+1; the operation must vanish.
        @(negedge clk);
        aV[0] = 8'd255; bV[0] = 8'd1; opV[0] = 1'b0; inValidV[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValidV[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetState(0);
        repeat (3) @(negedge clk);
        checkOutput("d0 after reset out_valid", outValidV[0], 0);
        checkOutput("d0 after reset in_ready", inReadyV[0], 1);
        applyStimulus(0, 8'd1, 8'd1, 1'b0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
